gpio_intr_sched: RTL



---
 rtl/gpio_intr_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gpio_intr_sched.sv
// Interrupt scheduler: picks one of eight pending GPIO interrupts, presents it to the CPU,
// tracks claim/complete, issues EOI pulses for edge sources and times out unclaimed requests.
module gpio_intr_sched #(
   parameter bit PRIO_RR = 1'b1,
   parameter int TMO_W   = 8
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic [7:0]       gpio_intr,
   input  logic [7:0]       gpio_inttype_level,
   input  logic             sched_en,
   input  logic             cpu_claim,
   input  logic             cpu_complete,
   input  logic [TMO_W-1:0] tmo_limit,
   input  logic             tmo_clr,
   output logic             irq_out,
   output logic [2:0]       irq_id,
   output logic [7:0]       gpio_porta_eoi,
   output logic             sched_busy,
   output logic             tmo_flag
);

   typedef enum logic [1:0] {IDLE, PEND, SERV, EOI} state_e;

   state_e           state_q, state_d;
   logic [2:0]       irq_id_q, irq_id_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             tmo_flag_q, tmo_flag_d;
   logic             post_eoi_q;
   logic             irq_out_q, busy_q;
   logic [7:0]       eoi_q;

   logic [7:0]       elig;
   logic [2:0]       start, idx, win;
   logic             found;
   logic [TMO_W:0]   cnt_inc;
   logic             tmo_hit;

   // The source just acknowledged is masked for one IDLE cycle while the GPIO block clears it.
   always_comb begin
      elig  = gpio_intr & ~(post_eoi_q ? (8'b1 << irq_id_q) : 8'b0);
      start = PRIO_RR ? rr_ptr_q : 3'd0;
      idx   = 3'd0;
      win   = 3'd0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = start + 3'(i);
         if (!found && elig[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // irq_out stays high exactly tmo_limit cycles, so the limit is hit one count early.
   always_comb begin
      cnt_inc = {1'b0, cnt_q} + {{TMO_W{1'b0}}, 1'b1};
      tmo_hit = (tmo_limit != '0) && (cnt_inc == {1'b0, tmo_limit});
   end

   always_comb begin
      state_d    = state_q;
      irq_id_d   = irq_id_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      tmo_flag_d = tmo_flag_q & ~tmo_clr;
      case (state_q)
         IDLE: begin
            if (sched_en && found) begin
               state_d  = PEND;
               irq_id_d = win;
               cnt_d    = '0;
            end
         end
         PEND: begin
            if (cpu_claim) begin
               state_d = SERV;
            end else if (!gpio_intr[irq_id_q] || !sched_en) begin
               state_d = IDLE;
            end else if (tmo_hit) begin
               state_d    = IDLE;
               tmo_flag_d = 1'b1;
               rr_ptr_d   = irq_id_q + 3'd1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_inc[TMO_W-1:0];
            end
         end
         SERV: begin
            if (cpu_complete) begin
               rr_ptr_d = irq_id_q + 3'd1;
               state_d  = gpio_inttype_level[irq_id_q] ? EOI : IDLE;
            end
         end
         EOI:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= IDLE;
         irq_id_q   <= 3'd0;
         rr_ptr_q   <= 3'd0;
         cnt_q      <= '0;
         tmo_flag_q <= 1'b0;
         post_eoi_q <= 1'b0;
         irq_out_q  <= 1'b0;
         busy_q     <= 1'b0;
         eoi_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         irq_id_q   <= irq_id_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
         tmo_flag_q <= tmo_flag_d;
         post_eoi_q <= (state_q == EOI);
         irq_out_q  <= (state_d == PEND);
         busy_q     <= (state_d != IDLE);
         eoi_q      <= (state_d == EOI) ? (8'b1 << irq_id_d) : 8'd0;
      end
   end

   assign irq_out        = irq_out_q;
   assign irq_id         = irq_id_q;
   assign gpio_porta_eoi = eoi_q;
   assign sched_busy     = busy_q;
   assign tmo_flag       = tmo_flag_q;

endmodule
